if_id_instr_buffer: RTL
=======================

// Module: if_id_instr_buffer
// PURPOSE
//  Instruction buffer between the IF fetch response path and the ID stage.
//  - Queues fetched, aligned instruction words together with their PC.
//  - Presents the oldest entry to ID with valid/ready semantics.
//  - Flags compressed and fetch-failed instructions.
//  - Flushes on every controller PC redirect.
// PARAMETERS
//  DEPTH  2  number of entries; power of two, >=2
//  PTR_W  $clog2(DEPTH)  read/write pointer width (derived, do not override)
// PORTS
//  clk                  in   1   core clock
//  rst_n                in   1   asynchronous active-low reset
//  pc_set_i             in   1   controller redirect; flushes all entries
//  halt_if_i            in   1   controller halt of IF; blocks pushes, pops still allowed
//  fetch_valid_i        in   1   fetch response valid
//  fetch_ready_o        out  1   buffer accepts fetch response
//  fetch_rdata_i        in   32  instruction word, already aligned
//  fetch_addr_i         in   32  PC of fetch_rdata_i
//  fetch_err_i          in   1   bus error on this fetch
//  instr_valid_o        out  1   head entry valid towards ID
//  id_ready_i           in   1   ID consumes head this cycle
//  instr_rdata_o        out  32  head instruction word
//  pc_id_o              out  32  head PC
//  is_compressed_o      out  1   head is compressed: instr_rdata_o[1:0] != 2'b11
//  is_fetch_failed_o    out  1   head carries a fetch error
//  occupancy_o          out  PTR_W+1  number of valid entries
// BEHAVIOUR
//  Reset (async on rst_n low):
//   - Pointers, count and err_lock clear to 0.
//   - Storage is not reset.
//   - Outputs: instr_valid_o=0, fetch_ready_o=0 while reset is asserted.
//     fetch_ready_o returns to 1 in the first cycle after release.
//   - Data outputs read X-free as 0: output mux gated by valid.
//  Push: fetch_valid_i && fetch_ready_o.
//   - fetch_ready_o = !halt_if_i && !err_lock && (count < DEPTH).
//   - fetch_ready_o is registered-state only; it has no combinational path from id_ready_i.
//  Pop: instr_valid_o && id_ready_i.
//   - instr_valid_o = (count != 0).
//   - Head fields come from the entry at rd_ptr.
//   - Head fields are stable while instr_valid_o && !id_ready_i.
//  Latency: an entry pushed in cycle N is visible to ID in cycle N+1 (no bypass).
//  Simultaneous push and pop:
//   - count is unchanged; both pointers advance.
//   - Legal at any non-full occupancy.
//   - When full, push is blocked because fetch_ready_o=0.
//  Pointers wrap modulo DEPTH. count is PTR_W+1 bits and saturates at DEPTH by construction.
//  Fetch error:
//   - A push with fetch_err_i=1 stores the entry with its err bit set and sets err_lock.
//   - err_lock forces fetch_ready_o=0 until pc_set_i.
//   - No entry ever follows an error entry.
//  Flush, pc_set_i=1 in cycle N:
//   - Next cycle: count=0, pointers=0, err_lock=0.
//   - Any push or pop in cycle N is discarded.
//   - instr_valid_o=0 in cycle N+1.
//   - Flush wins over every other event.
//  halt_if_i: ID may drain remaining entries; no new pushes are accepted while it is high.
//  Assertions:
//   - No push when full.
//   - occupancy_o <= DEPTH.
//   - instr_valid_o==0 in the cycle after a pc_set_i.
// TESTING
//  T1: push 0x00A00093 @PC 0x80 with id_ready_i=0
//      -> next cycle instr_valid_o=1, pc_id_o=0x80, is_compressed_o=0, occupancy_o=1.
//  T2: DEPTH=2; push 0x4505 and 0x00000013 with id_ready_i=0
//      -> occupancy_o=2, fetch_ready_o=0.
//      Then id_ready_i=1 -> head 0x4505 with is_compressed_o=1, then 0x13, then empty.
//  T3: occupancy_o=1; push and pop in the same cycle
//      -> occupancy_o stays 1 and the new PC appears at the head; repeat 5x across pointer wrap.
//  T4: push with fetch_err_i=1 @PC 0x100
//      -> is_fetch_failed_o=1 at head, fetch_ready_o=0.
//      pc_set_i pulse -> buffer empty and fetch_ready_o=1 next cycle.
//  T5: full buffer; pc_set_i=1 together with fetch_valid_i and id_ready_i
//      -> next cycle occupancy_o=0, instr_valid_o=0, no entry accepted.
//  T6: halt_if_i=1 with 2 entries
//      -> fetch_ready_o=0, ID drains both.
//      Assert rst_n=0 mid-stream -> instr_valid_o=0 immediately.

Source files
------------

// File: rtl/if_id_instr_buffer.sv
// Instruction buffer between the IF fetch response path and the ID stage.
// Small circular FIFO of {instr, pc, err}; flushed on every controller redirect.
module if_id_instr_buffer #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_set_i,
    input  logic              halt_if_i,
    input  logic              fetch_valid_i,
    output logic              fetch_ready_o,
    input  logic [31:0]       fetch_rdata_i,
    input  logic [31:0]       fetch_addr_i,
    input  logic              fetch_err_i,
    output logic              instr_valid_o,
    input  logic              id_ready_i,
    output logic [31:0]       instr_rdata_o,
    output logic [31:0]       pc_id_o,
    output logic              is_compressed_o,
    output logic              is_fetch_failed_o,
    output logic [PTR_W:0]    occupancy_o
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];
    logic             mem_err   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             err_lock;

    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count_nxt;
    logic             err_lock_nxt;

    logic             push;
    logic             pop;
    logic             push_raw;
    logic             pop_raw;

    // Gating with rst_n keeps ready low for the whole reset window and lets it
    // rise immediately on release, before the first clock edge.
    assign fetch_ready_o = rst_n && !halt_if_i && !err_lock && (count < DEPTH_C);
    assign instr_valid_o = (count != '0);

    assign push_raw = fetch_valid_i && fetch_ready_o;
    assign pop_raw  = instr_valid_o && id_ready_i;

    // A redirect discards whatever handshakes happen in the same cycle.
    assign push = push_raw && !pc_set_i;
    assign pop  = pop_raw && !pc_set_i;

    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        err_lock_nxt = err_lock;

        if (pc_set_i) begin
            wr_ptr_nxt   = '0;
            rd_ptr_nxt   = '0;
            count_nxt    = '0;
            err_lock_nxt = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_nxt = wr_ptr + PTR_ONE;
                if (fetch_err_i) begin
                    err_lock_nxt = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_lock <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            err_lock <= err_lock_nxt;
        end
    end

    // Storage carries no reset; the output mux below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= fetch_rdata_i;
            mem_pc[wr_ptr]    <= fetch_addr_i;
            mem_err[wr_ptr]   <= fetch_err_i;
        end
    end

    always_comb begin
        instr_rdata_o     = '0;
        pc_id_o           = '0;
        is_fetch_failed_o = 1'b0;
        if (instr_valid_o) begin
            instr_rdata_o     = mem_instr[rd_ptr];
            pc_id_o           = mem_pc[rd_ptr];
            is_fetch_failed_o = mem_err[rd_ptr];
        end
    end

    assign is_compressed_o = instr_valid_o && (instr_rdata_o[1:0] != 2'b11);
    assign occupancy_o     = count;

    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_raw && (count == DEPTH_C)));

    a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
        occupancy_o <= DEPTH_C);

    a_flush_empty : assert property (@(posedge clk) disable iff (!rst_n)
        pc_set_i |=> !instr_valid_o);

endmodule
